// File: rtl/vga_ctrl_pkg.sv
// Shared definitions for the VGA control path.
//   state_e         : command decoder FSM encoding
//   READ_CODE_DEF   : data nibble that denotes a register read
//   ERR_BYTE_DEF    : response byte returned on bus timeout
//   TIMEOUT_DEF     : default bus timeout in cycles
//   REG_*           : register-file address map
package vga_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2,
    ST_ERR   = 2'd3
  } state_e;

  localparam int         TIMEOUT_DEF   = 16;
  localparam logic [3:0] READ_CODE_DEF = 4'hF;
  localparam logic [7:0] ERR_BYTE_DEF  = 8'hEE;

  // Register-file address map
  localparam logic [3:0] REG_RESOLUTION = 4'hD;

endpackage

// File: rtl/uart_cmd_decoder.sv
// UART command decoder: turns each received byte into one register-file bus
// transaction ({address, data} = rx byte; data == READ_CODE requests a read)
// and returns one response byte: read data, write echo, or ERR_BYTE when no
// register file acknowledges within TIMEOUT cycles.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   rx_data, rx_valid     received byte + one-cycle strobe
//   address, data, valid  bus request (valid is a level)
//   ack, rd_data, rd_valid bus acknowledge and read-back nibble
//   tx_data, tx_valid, tx_ready  response byte, held until accepted
//   busy                  high whenever the FSM is not idle
//   overrun               sticky: a byte arrived while busy and was dropped
module uart_cmd_decoder
  import vga_ctrl_pkg::*;
#(
  parameter int         TIMEOUT   = TIMEOUT_DEF,
  parameter logic [7:0] ERR_BYTE  = ERR_BYTE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [3:0] address,
  output logic [3:0] data,
  output logic       valid,
  input  logic       ack,
  input  logic [3:0] rd_data,
  input  logic       rd_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       overrun
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    addr_q, addr_d;
  logic [3:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic          busy_q, busy_d;
  logic          overrun_q, overrun_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    valid_d    = valid_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    overrun_d  = overrun_q;

    // Single-entry front end: anything arriving while busy is lost.
    if (rx_valid && state_q != ST_IDLE) overrun_d = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          addr_d  = rx_data[7:4];
          data_d  = rx_data[3:0];
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // ack takes priority over a timeout in the same cycle; rd_valid only
        // counts when qualified by ack.
        if (ack) begin
          valid_d    = 1'b0;
          tx_data_d  = rd_valid ? {addr_q, rd_data} : {addr_q, data_q};
          tx_valid_d = 1'b1;
          state_d    = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          valid_d    = 1'b0;
          tx_data_d  = ERR_BYTE;
          tx_valid_d = 1'b1;
          state_d    = ST_ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP, ST_ERR: begin
        if (tx_valid_q && tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
    end
  end

  assign address  = addr_q;
  assign data     = data_q;
  assign valid    = valid_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign overrun  = overrun_q;

endmodule
